// File: rtl/eq_pkg.sv
// Shared types, constants and the 16-bit saturation helper for the equalizer band scheduler.
// Build option: EQ_VOLUME_EN adds the VOL state (master volume pass through the shared scaler).
// No clocked logic here.
package eq_pkg;

  localparam int AUDIO_W     = 16;
  localparam int GAIN_W      = 12;
  localparam int SCALE_SHIFT = 10;
  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

`ifdef EQ_VOLUME_EN
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, VOL} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
`endif

  // Clamp a sign-extended value into the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic signed [31:0] v);
    logic [15:0] r;
    if (v > 32'sd32767) begin
      r = SAT_MAX;
    end else if (v < -32'sd32768) begin
      r = SAT_MIN;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/band_mult_sat.sv
// Shared scaler: signed audio times unsigned 12-bit gain (0x400 = unity), >>10, saturated to 16 bits.
// Purely combinational; zero latency.
// No flow control; the caller registers the operands.
module band_mult_sat
  import eq_pkg::*;
(
  input  logic [AUDIO_W-1:0] audio,
  input  logic [GAIN_W-1:0]  gain,
  output logic [AUDIO_W-1:0] result
);

  localparam int P_W   = AUDIO_W + GAIN_W + 1;
  localparam int TOP_L = AUDIO_W + SCALE_SHIFT - 1;

  logic signed [AUDIO_W-1:0] a_s;
  logic signed [GAIN_W:0]    g_s;
  logic signed [P_W-1:0]     p;
  logic [P_W-1:TOP_L]        top;
  logic                      unused_lsb;

  assign a_s        = audio;
  assign g_s        = {1'b0, gain};
  assign p          = a_s * g_s;
  assign top        = p[P_W-1:TOP_L];
  assign unused_lsb = ^p[SCALE_SHIFT-1:0];

  // Take the scaled window; clamp when the bits above it are not a pure sign extension.
  always_comb begin
    result = p[TOP_L:SCALE_SHIFT];
    if (!((&top) || (~|top))) begin
      result = p[P_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/eq_band_sched.sv
// Equalizer band scheduler: snapshots all bands, scales one per cycle through one shared scaler, sums.
// Latency N+1 edges from accepted smpl_vld to eq_vld (N+2 with EQ_VOLUME_EN for the volume pass).
// No backpressure: smpl_vld while busy is dropped and flags sticky ovr.
module eq_band_sched
  import eq_pkg::*;
#(
  parameter int NUM_BANDS = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         smpl_vld,
  input  logic [NUM_BANDS*AUDIO_W-1:0] band_audio,
  input  logic [NUM_BANDS*GAIN_W-1:0]  band_pot,
  input  logic [GAIN_W-1:0]            volume,
  output logic [AUDIO_W-1:0]           eq_out,
  output logic                         eq_vld,
  output logic                         busy,
  output logic                         ovr
);

  localparam int ACC_W = AUDIO_W + $clog2(NUM_BANDS);
  localparam int IDX_W = $clog2(NUM_BANDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [NUM_BANDS*AUDIO_W-1:0] audio_snap_q, audio_snap_d;
  logic [NUM_BANDS*GAIN_W-1:0]  pot_snap_q, pot_snap_d;
  logic [AUDIO_W-1:0]           op_audio_q, op_audio_d;
  logic [GAIN_W-1:0]            op_gain_q, op_gain_d;
  logic [AUDIO_W-1:0]           eq_out_q, eq_out_d;
  logic                         eq_vld_q, eq_vld_d;
  logic                         ovr_q, ovr_d;

  logic [AUDIO_W-1:0]           scaled;
  logic signed [ACC_W-1:0]      scaled_ext;
  logic signed [ACC_W-1:0]      sum;
  logic [AUDIO_W-1:0]           sum_sat;

  band_mult_sat u_mult (
    .audio  (op_audio_q),
    .gain   (op_gain_q),
    .result (scaled)
  );

  assign scaled_ext = {{(ACC_W-AUDIO_W){scaled[AUDIO_W-1]}}, scaled};
  assign sum        = acc_q + scaled_ext;
  assign sum_sat    = sat16(32'(sum));

`ifndef EQ_VOLUME_EN
  logic unused_volume;
  assign unused_volume = ^volume;
`endif

  // Next-state: snapshot on accept, feed one band per cycle, accumulate the previous band's product.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    audio_snap_d = audio_snap_q;
    pot_snap_d   = pot_snap_q;
    op_audio_d   = op_audio_q;
    op_gain_d    = op_gain_q;
    eq_out_d     = eq_out_q;
    eq_vld_d     = 1'b0;
    ovr_d        = ovr_q | (smpl_vld && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (smpl_vld) begin
          audio_snap_d = band_audio;
          pot_snap_d   = band_pot;
          acc_d        = '0;
          idx_d        = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        op_audio_d = audio_snap_q[idx_q*AUDIO_W +: AUDIO_W];
        op_gain_d  = pot_snap_q[idx_q*GAIN_W +: GAIN_W];
        idx_d      = idx_q + IDX_W'(1);
        // The operand register is still empty on the first issue cycle.
        if (idx_q != '0) begin
          acc_d = sum;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
`ifdef EQ_VOLUME_EN
        op_audio_d = sum_sat;
        op_gain_d  = volume;
        state_d    = VOL;
`else
        eq_out_d   = sum_sat;
        eq_vld_d   = 1'b1;
        state_d    = IDLE;
`endif
      end
`ifdef EQ_VOLUME_EN
      VOL: begin
        eq_out_d = scaled;
        eq_vld_d = 1'b1;
        state_d  = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight computation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      audio_snap_q <= '0;
      pot_snap_q   <= '0;
      op_audio_q   <= '0;
      op_gain_q    <= '0;
      eq_out_q     <= '0;
      eq_vld_q     <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      audio_snap_q <= audio_snap_d;
      pot_snap_q   <= pot_snap_d;
      op_audio_q   <= op_audio_d;
      op_gain_q    <= op_gain_d;
      eq_out_q     <= eq_out_d;
      eq_vld_q     <= eq_vld_d;
      ovr_q        <= ovr_d;
    end
  end

  assign eq_out = eq_out_q;
  assign eq_vld = eq_vld_q;
  assign busy   = (state_q != IDLE);
  assign ovr    = ovr_q;

endmodule

// File: tb/tb_eq_band_sched.sv
// Bench for eq_band_sched: directed samples, expected sums queued at issue, popped on eq_vld.
module tb_eq_band_sched;

  localparam int N = 5;
`ifdef EQ_VOLUME_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N + 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            smpl_vld = 1'b0;
  logic [N*16-1:0] band_audio = '0;
  logic [N*12-1:0] band_pot = '0;
  logic [11:0]     volume = 12'h400;
  logic [15:0]     eq_out;
  logic            eq_vld;
  logic            busy;
  logic            ovr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] val;
    int          cyc;
    string       name;
  } exp_t;
  exp_t sb[$];

  eq_band_sched #(.NUM_BANDS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .smpl_vld   (smpl_vld),
    .band_audio (band_audio),
    .band_pot   (band_pot),
    .volume     (volume),
    .eq_out     (eq_out),
    .eq_vld     (eq_vld),
    .busy       (busy),
    .ovr        (ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every eq_vld pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && eq_vld) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_eq_vld: got eq_out %0h at cycle %0d expected no pulse", eq_out, cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_data"}, 32'(eq_out), 32'(e.val));
        chk({e.name, "_cycle"}, cyc, e.cyc);
        chk({e.name, "_busy_fall"}, 32'(busy), 32'd0);
      end
    end
  end

  task automatic set_band(input int i, input int a, input logic [11:0] p);
    band_audio[i*16 +: 16] = 16'(a);
    band_pot[i*12 +: 12]   = p;
  endtask

  task automatic set_all(input int a, input logic [11:0] p);
    for (int i = 0; i < N; i++) set_band(i, a, p);
  endtask

  // Called at a negedge; returns at the negedge after E0.
  task automatic start(input string name, input logic [15:0] expv);
    smpl_vld = 1'b1;
    sb.push_back('{val: expv, cyc: cyc + 1 + LAT, name: name});
    @(negedge clk);
    smpl_vld = 1'b0;
    chk({name, "_busy_rise"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout: busy still %0b after %0d cycles expected 0", name, busy, n);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_eq_out", 32'(eq_out), 32'd0);
    chk("reset_eq_vld", 32'(eq_vld), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ovr", 32'(ovr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    set_all(1000, 12'h400);
    start("unity", 16'd5000);
    wait_idle("unity");

    set_all(0, 12'h400);
    set_band(0, 32767, 12'hFFF);
    start("band_sat", 16'h7FFF);
    wait_idle("band_sat");

    set_all(-20000, 12'h400);
    start("sum_sat", 16'h8000);
    wait_idle("sum_sat");

    // 1000 - 1000 + 6000 + 1599 (400*4095>>10) - 1 (floor of -1023/1024) = 7598
    set_band(0, 1000, 12'h400);
    set_band(1, -2000, 12'h200);
    set_band(2, 3000, 12'h800);
    set_band(3, 400, 12'hFFF);
    set_band(4, -1, 12'h3FF);
    start("mixed", 16'd7598);
    wait_idle("mixed");
    chk("ovr_clear", 32'(ovr), 32'd0);

    // Second strobe lands on E3 with different data; it must be dropped.
    set_all(1000, 12'h400);
    start("overrun", 16'd5000);
    repeat (2) @(negedge clk);
    set_all(0, 12'h400);
    smpl_vld = 1'b1;
    @(negedge clk);
    smpl_vld = 1'b0;
    chk("overrun_ovr", 32'(ovr), 32'd1);
    wait_idle("overrun");
    repeat (N + 3) @(negedge clk);

    // Reset just after E3: no result may appear.
    set_all(1000, 12'h400);
    smpl_vld = 1'b1;
    @(negedge clk);
    smpl_vld = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_eq_vld", 32'(eq_vld), 32'd0);
    chk("midrst_eq_out", 32'(eq_out), 32'd0);
    chk("midrst_ovr", 32'(ovr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 4) @(negedge clk);
    chk("midrst_idle", 32'(busy), 32'd0);

    set_all(1000, 12'h400);
    start("post_reset", 16'd5000);
    wait_idle("post_reset");

`ifdef EQ_VOLUME_EN
    volume = 12'h200;
    set_all(1000, 12'h400);
    start("volume", 16'd2500);
    wait_idle("volume");
    volume = 12'h400;
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eq_band_sched.md
# eq_band_sched

Time-multiplexed band scaler and summer for the equalizer. The block captures one sample from each band FIR plus its slide-pot gain and runs every band through a single shared 13x16 saturating scaler, one band per cycle. It accumulates the scaled bands into one saturated 16-bit output. It sits between the band FIR bank and the output/DAC path and replaces one scaler per band.

## Interface
- NUM_BANDS, default 5: number of equalizer bands; valid range 2..8.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- smpl_vld  input  1  one-cycle strobe; band_audio/band_pot valid.
- band_audio  input  NUM_BANDS*16  signed band samples; band i at [16i+15:16i].
- band_pot  input  NUM_BANDS*12  unsigned gains, upper 12 bits of each pot A2D reading; band i at [12i+11:12i].
- volume  input  12  master gain; used only with EQ_VOLUME_EN.
- eq_out  output  16  signed saturated equalizer sum.
- eq_vld  output  1  one-cycle pulse; eq_out updated.
- busy  output  1  high whenever state != IDLE.
- ovr  output  1  sticky; a smpl_vld was dropped.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, and VOL (VOL exists only with the macro).
- Scaler arithmetic:
  - p = signed(audio) * signed({1'b0, gain}) gives a 29-bit product.
  - result = p[25:10].
  - If p[28:25] are not all equal, the result saturates to 0x7FFF (p[28] = 0) or 0x8000 (p[28] = 1).
  - gain 0x400 is unity; 0xFFF is about 4x.
- Operand register (audio, gain) feeds the scaler; this is the only multiplier in the block.
- Accumulator width is 16+clog2(NUM_BANDS) bits, signed; each scaled band is sign-extended before adding.
- IDLE, smpl_vld=1:
  - Snapshot all band_audio/band_pot.
  - Clear the accumulator.
  - Set idx=0 and go to ISSUE.
- ISSUE:
  - Each cycle, load the operand register with band idx and increment idx.
  - From the second ISSUE cycle on, add the scaler output to the accumulator each cycle.
  - After band NUM_BANDS-1 is loaded, go to DRAIN.
- DRAIN: final sum = acc + scaler output; saturate it to 16 bits.
  - Without the macro: load eq_out with the saturated sum, pulse eq_vld, go to IDLE.
  - With the macro: load the operand register with (saturated sum, volume) and go to VOL.
- VOL (macro only): load eq_out with the scaler output, pulse eq_vld, go to IDLE.
- smpl_vld outside IDLE:
  - The sample is dropped and ovr is set.
  - The snapshot and the in-flight computation are unaffected.
  - This applies equally to the DRAIN and VOL cycles.
- ovr clears only on reset.
- eq_out holds its value between pulses.

## Timing
- Edge E0 is the clk edge where smpl_vld=1 is sampled in IDLE.
- Operand loads occur at E1..E(N); accumulates at E2..E(N+1).
- Without the macro: eq_out/eq_vld update at E(N+1); eq_vld is high for exactly the cycle following E(N+1). Latency is N+1 edges; for N=5, E6.
- With the macro: update at E(N+2); latency N+2 edges.
- busy rises after E0 and falls on the same edge that raises eq_vld.
- The next sample can be accepted at the edge following the eq_vld cycle start, i.e. in IDLE.
- Reset values: eq_out=0, eq_vld=0, busy=0, ovr=0, state IDLE, idx=0, accumulator, snapshot and operand registers all 0.
- rst_n low mid-operation aborts immediately with no eq_vld pulse. After release, the block waits in IDLE for a new smpl_vld.

## Configuration
- EQ_VOLUME_EN defined:
  - VOL state is compiled in; the summed output is scaled by volume using the shared scaler with the same saturation rules.
  - Latency is N+2.
- EQ_VOLUME_EN undefined:
  - No VOL state; the volume port exists but is ignored.
  - eq_out is the saturated band sum; latency is N+1.

## Structure
- Package eq_pkg holds:
  - the state enum;
  - constants AUDIO_W=16, GAIN_W=12, SCALE_SHIFT=10, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000;
  - the sat16 helper function.
- Sub-module band_mult_sat is the combinational signed 13x16 multiply, shift and saturate, instantiated once.

## Test plan
- Reset: while rst_n=0, check eq_out=0, eq_vld=0, busy=0, ovr=0.
- Unity: all pots 0x400, all audio +1000, N=5 -> eq_out=5000 (0x1388), eq_vld high only in the cycle after E6.
- Band saturation: band0 audio 0x7FFF with pot 0xFFF, others audio 0 -> eq_out=0x7FFF.
- Sum saturation: all audio -20000, pots 0x400 -> sum -100000 -> eq_out=0x8000.
- Overrun: second smpl_vld at E3 -> ovr=1, eq_out from the first sample is still 5000 at E6, and no second eq_vld.
- Reset mid-op at E3 -> no eq_vld, busy=0.
- With EQ_VOLUME_EN: volume 0x200, unity pots, audio 1000 -> eq_out=2500 at E7.
